// File: rtl/eth_pkg.sv
// Shared frame definitions for the transmitter and receiver: state encoding,
// fixed octets, field lengths and the longitudinal check helpers.
package eth_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PREAMBLE,
    ST_SFD,
    ST_MACDST,
    ST_MACSRC,
    ST_PLLEN,
    ST_PL,
    ST_FCS,
    ST_IFG
  } frame_state_t;

  localparam logic [7:0] PreambleOctet = 8'hAA;
  localparam logic [7:0] SFDOctet      = 8'hAB;

  localparam int PREAMBLE_LEN = 7;
  localparam int SFD_LEN      = 1;
  localparam int MAC_LEN      = 6;
  localparam int LEN_LEN      = 2;
  localparam int FCS_LEN      = 4;

  function automatic logic [7:0] mac_sum(input logic [47:0] mac);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < MAC_LEN; i++) s = s + mac[i*8 +: 8];
    return s;
  endfunction

  // Two's complement of the running byte sum, so sum + fcs == 0 mod 256.
  function automatic logic [7:0] lrc(input logic [7:0] sum);
    return (~sum) + 8'd1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO; rd_data always shows the head entry.
module byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/xmit_top.sv
// Frame transmitter: buffers a payload, then streams preamble, SFD, MACs,
// length, payload and a 4-byte LRC check, one byte per cycle.
//
//   state    | meaning
//   IDLE     | waiting for req; rejects bad lengths with err
//   LOAD     | accepting pl_len payload bytes into the FIFO
//   PREAMBLE | 7 x 8'hAA
//   SFD      | 1 x 8'hAB
//   MACDST   | destination MAC, MSB first
//   MACSRC   | source MAC, MSB first
//   PLLEN    | payload length, MSB first
//   PL       | payload bytes from the FIFO
//   FCS      | 4 x LRC byte
//   IFG      | inter-frame gap, tx_data=0
module xmit_top
  import eth_pkg::*;
#(
  parameter logic [47:0] SRC_MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter int          FIFO_DEPTH   = 64,
  parameter int          IFG_CYCLES   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [47:0] dest_mac,
  input  logic [15:0] pl_len,
  input  logic [7:0]  pl_data,
  input  logic        pl_vld,
  output logic        pl_rdy,
  output logic        req_rdy,
  output logic        err,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        done
);

  frame_state_t state, state_nxt;
  logic [15:0]  cnt, cnt_nxt;
  logic [15:0]  len_q;
  logic [47:0]  dest_q;
  logic [7:0]   csum;
  logic [7:0]   tx_data_d;
  logic         tx_start_d, done_d, err_d;
  logic         bad_len, accept, wr_en, rd_en;
  logic [7:0]   rd_data;
  logic         full, empty;

  assign bad_len = (pl_len == 16'd0) || ({1'b0, pl_len} > 17'(FIFO_DEPTH));
  assign accept  = (state == ST_IDLE) && req && !bad_len;
  assign req_rdy = (state == ST_IDLE);
  assign pl_rdy  = (state == ST_LOAD) && !full;
  assign wr_en   = pl_vld && pl_rdy;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (pl_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      len_q    <= '0;
      dest_q   <= '0;
      csum     <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tx_data  <= tx_data_d;
      tx_start <= tx_start_d;
      done     <= done_d;
      err      <= err_d;
      if (accept) begin
        len_q  <= pl_len;
        dest_q <= dest_mac;
        csum   <= mac_sum(dest_mac) + mac_sum(SRC_MAC_ADDR) + pl_len[15:8] + pl_len[7:0];
      end else if (wr_en) begin
        csum <= csum + pl_data;
      end
    end
  end

  // Next state and the counter value that will accompany it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (bad_len) begin
            err_d = 1'b1;
          end else begin
            state_nxt = ST_LOAD;
            cnt_nxt   = pl_len;
          end
        end
      end
      ST_LOAD: begin
        if (wr_en) begin
          if (cnt == 16'd1) begin
            state_nxt = ST_PREAMBLE;
            cnt_nxt   = 16'(PREAMBLE_LEN - 1);
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end
      end
      default: begin
        if (cnt != 16'd0) begin
          cnt_nxt = cnt - 16'd1;
        end else begin
          case (state)
            ST_PREAMBLE: begin state_nxt = ST_SFD;    cnt_nxt = 16'(SFD_LEN - 1); end
            ST_SFD:      begin state_nxt = ST_MACDST; cnt_nxt = 16'(MAC_LEN - 1); end
            ST_MACDST:   begin state_nxt = ST_MACSRC; cnt_nxt = 16'(MAC_LEN - 1); end
            ST_MACSRC:   begin state_nxt = ST_PLLEN;  cnt_nxt = 16'(LEN_LEN - 1); end
            ST_PLLEN:    begin state_nxt = ST_PL;     cnt_nxt = len_q - 16'd1; end
            ST_PL:       begin state_nxt = ST_FCS;    cnt_nxt = 16'(FCS_LEN - 1); end
            ST_FCS:      begin state_nxt = ST_IFG;    cnt_nxt = 16'(IFG_CYCLES - 1); end
            default:     begin state_nxt = ST_IDLE;   cnt_nxt = '0; end
          endcase
        end
      end
    endcase
  end

  // Output bytes are decoded from the next state so they can be registered
  // and still appear in the cycle their state occupies.
  always_comb begin
    tx_data_d  = 8'h00;
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    case (state_nxt)
      ST_PREAMBLE: begin
        tx_data_d  = PreambleOctet;
        tx_start_d = (state == ST_LOAD);
      end
      ST_SFD:    tx_data_d = SFDOctet;
      ST_MACDST: tx_data_d = dest_q[{cnt_nxt[2:0], 3'b000} +: 8];
      ST_MACSRC: tx_data_d = SRC_MAC_ADDR[{cnt_nxt[2:0], 3'b000} +: 8];
      ST_PLLEN:  tx_data_d = cnt_nxt[0] ? len_q[15:8] : len_q[7:0];
      ST_PL: begin
        tx_data_d = rd_data;
        rd_en     = !empty;
      end
      ST_FCS: begin
        tx_data_d = lrc(csum);
        done_d    = (cnt_nxt == 16'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xmit_top.sv
// Self-checking bench for xmit_top: directed and random frames compared
// byte-for-byte against a frame model built from the field layout.
module tb_xmit_top;

  localparam int          DEPTH = 64;
  localparam int          IFG   = 12;
  localparam logic [47:0] SRC   = 48'h02_00_00_00_00_01;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [47:0] dest_mac = '0;
  logic [15:0] pl_len = '0;
  logic [7:0]  pl_data = '0;
  logic        pl_vld = 1'b0;
  logic        pl_rdy, req_rdy, err, tx_start, done;
  logic [7:0]  tx_data;

  int total = 0;
  int bad   = 0;
  logic       hold_req = 1'b0;
  logic [7:0] pl_buf [256];

  xmit_top #(.SRC_MAC_ADDR(SRC), .FIFO_DEPTH(DEPTH), .IFG_CYCLES(IFG)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dest_mac (dest_mac),
    .pl_len   (pl_len),
    .pl_data  (pl_data),
    .pl_vld   (pl_vld),
    .pl_rdy   (pl_rdy),
    .req_rdy  (req_rdy),
    .err      (err),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_pl_rdy"}, pl_rdy, 0);
    chk({tag, "_req_rdy"}, req_rdy, 1);
  endtask

  // gap: 0 = pl_vld always 1, 1 = pattern 1,0,0,1,1,0,1, 2 = random.
  // abort_at >= 0 asserts reset when that frame byte index is on the wire.
  task automatic send_frame(input logic [47:0] d, input int len, input int gap, input int abort_at);
    logic [7:0] exp_q[$];
    logic [47:0] src_v;
    logic [6:0] pat;
    int sum, idx, cyc, n, fcs;
    logic v;

    src_v = SRC;
    pat   = 7'b1011001;
    exp_q = {};
    for (int i = 0; i < 7; i++) exp_q.push_back(8'hAA);
    exp_q.push_back(8'hAB);
    for (int i = 5; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(src_v[i*8 +: 8]);
    exp_q.push_back(8'(len / 256));
    exp_q.push_back(8'(len % 256));
    for (int i = 0; i < len; i++) exp_q.push_back(pl_buf[i]);
    sum = 0;
    for (int i = 8; i < exp_q.size(); i++) sum += int'(exp_q[i]);
    fcs = (256 - (sum % 256)) % 256;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(fcs));
    n = exp_q.size();

    chk("req_rdy_idle", req_rdy, 1);
    req = 1'b1;
    dest_mac = d;
    pl_len = 16'(len);
    tick();
    req = hold_req;
    chk("pl_rdy_after_accept", pl_rdy, 1);

    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 2000) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = pat[cyc % 7];
        default: v = 1'($urandom_range(0, 1));
      endcase
      pl_vld  = v;
      pl_data = v ? pl_buf[idx] : 8'($urandom);
      chk("pl_rdy_load", pl_rdy, 1);
      chk("no_start_in_load", tx_start, 0);
      tick();
      if (v) idx++;
      cyc++;
    end
    pl_vld  = 1'b0;
    pl_data = '0;
    chk("load_count", idx, len);

    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_frame_reset");
        #2;
        rst = 1'b1;
        tick();
        return;
      end
      chk($sformatf("tx_data[%0d]", i), tx_data, exp_q[i]);
      chk($sformatf("tx_start[%0d]", i), tx_start, (i == 0));
      chk($sformatf("done[%0d]", i), done, (i == n - 1));
      chk($sformatf("pl_rdy_tx[%0d]", i), pl_rdy, 0);
      tick();
    end
    for (int i = 0; i < IFG; i++) begin
      chk($sformatf("ifg_data[%0d]", i), tx_data, 0);
      chk($sformatf("ifg_busy[%0d]", i), req_rdy, 0);
      tick();
    end
    chk("req_rdy_after_ifg", req_rdy, 1);
  endtask

  task automatic reject(input logic [15:0] len);
    chk("rej_req_rdy", req_rdy, 1);
    req = 1'b1;
    pl_len = len;
    dest_mac = 48'h11_22_33_44_55_66;
    tick();
    req = 1'b0;
    chk($sformatf("rej_err_len%0d", len), err, 1);
    chk("rej_pl_rdy", pl_rdy, 0);
    chk("rej_stay_idle", req_rdy, 1);
    chk("rej_no_start", tx_start, 0);
    tick();
    chk("rej_err_pulse_end", err, 0);
    chk("rej_pl_rdy2", pl_rdy, 0);
    chk("rej_no_start2", tx_start, 0);
  endtask

  initial begin
    #2;
    chk_reset_outputs("reset");
    #10;
    rst = 1'b1;
    tick();
    chk_reset_outputs("post_reset");

    pl_buf[0] = 8'h01; pl_buf[1] = 8'h02; pl_buf[2] = 8'h03;
    send_frame(48'h00_0a_95_9d_68_16, 3, 0, -1);

    reject(16'd0);
    reject(16'd65);

    pl_buf[0] = 8'h5a; pl_buf[1] = 8'hc3; pl_buf[2] = 8'h0f; pl_buf[3] = 8'h99;
    send_frame(48'hde_ad_be_ef_00_42, 4, 1, -1);

    for (int i = 0; i < DEPTH; i++) pl_buf[i] = 8'(i);
    send_frame(48'hff_ff_ff_ff_ff_ff, DEPTH, 0, -1);

    for (int k = 0; k < 6; k++) begin
      int len;
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < len; i++) pl_buf[i] = 8'($urandom);
      send_frame({16'($urandom), 32'($urandom)}, len, 2, -1);
    end

    for (int i = 0; i < 10; i++) pl_buf[i] = 8'($urandom);
    send_frame(48'h00_11_22_33_44_55, 10, 0, 8 + 12 + 2 + 4);
    chk_reset_outputs("after_reset_release");
    pl_buf[0] = 8'he7;
    send_frame(48'h0a_0b_0c_0d_0e_0f, 1, 2, -1);

    pl_buf[0] = 8'h10; pl_buf[1] = 8'h20;
    hold_req = 1'b1;
    send_frame(48'h00_0a_95_9d_68_16, 2, 0, -1);
    hold_req = 1'b0;
    send_frame(48'h00_0a_95_9d_68_16, 2, 0, -1);
    tick();
    chk("idle_after_b2b", req_rdy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
